// File: rtl/serial_parity_receiver.sv
// Receiving end of the XOR-parity serial link: start bit, DATA_W data bits
// LSB first, parity bit, stop bit; word and error flags leave on a valid pulse.
module serial_parity_receiver #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Handshake: rx_bit is consumed on every rising edge where rx_valid=1;
    // rx_valid=0 freezes the FSM and datapath. data_valid is a one-cycle
    // strobe with no back-pressure; data_out and the flags hold between strobes.
    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              acc;
    logic              par_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (rx_valid) begin
            case (state)
                IDLE:    if (!rx_bit) state_next = DATA;
                DATA:    if (bit_cnt == LAST_IDX) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            acc         <= 1'b0;
            par_pending <= 1'b0;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        acc       <= 1'b0;
                    end
                end
                DATA: begin
                    shift_reg[bit_cnt] <= rx_bit;
                    acc                <= acc ^ rx_bit;
                    bit_cnt            <= bit_cnt + 1'b1;
                end
                PARITY: begin
                    par_pending <= acc ^ rx_bit ^ ODD_PARITY;
                end
                default: ;
            endcase
        end
    end

    // The stop bit is only checked, never reused as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rx_valid && state == STOP) begin
                data_out   <= shift_reg;
                parity_err <= par_pending;
                frame_err  <= ~rx_bit;
                data_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Directed bench for serial_parity_receiver: even-parity and odd-parity
// instances share one serial stream; expectations are hand-computed.
module tb_serial_parity_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_bit = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] e_data, o_data;
    logic       e_dv, e_perr, e_ferr, e_busy;
    logic       o_dv, o_perr, o_ferr, o_busy;

    int checks = 0;
    int failures = 0;
    int e_pulses = 0;
    int o_pulses = 0;
    int lat;
    int p0;

    serial_parity_receiver #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .data_out(e_data), .data_valid(e_dv), .parity_err(e_perr),
        .frame_err(e_ferr), .busy(e_busy)
    );

    serial_parity_receiver #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .rx_bit(rx_bit), .rx_valid(rx_valid),
        .data_out(o_data), .data_valid(o_dv), .parity_err(o_perr),
        .frame_err(o_ferr), .busy(o_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (e_dv) e_pulses++;
        if (o_dv) o_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic b, inout int n);
        rx_valid = 1'b1;
        rx_bit   = b;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic stall(input int cycles, inout int n);
        for (int i = 0; i < cycles; i++) begin
            rx_valid = 1'b0;
            rx_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic idle_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rx_valid = 1'b0;
            rx_bit   = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the cycle (start-bit cycle = 1) in which data_valid is expected.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input bit stalls, output int dv_cycle);
        int n = 0;
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], n);
            if (stalls && i == 2) stall(3, n);
        end
        if (stalls) stall(1, n);
        drive_bit(par, n);
        drive_bit(stp, n);
        rx_valid = 1'b0;
        rx_bit   = 1'b1;
        dv_cycle = n + 1;
    endtask

    initial begin
        int n;
        #1;
        check("reset_data_out", {24'd0, e_data}, 32'h0);
        check("reset_flags", {28'd0, e_dv, e_perr, e_ferr, e_busy}, 32'h0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);

        // 0xA5 even parity, clean
        p0 = e_pulses;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, lat);
        check("a5_latency", lat, 12);
        check("a5_dv", e_dv, 1);
        check("a5_busy_at_dv", e_busy, 0);
        check("a5_data", e_data, 8'hA5);
        check("a5_perr", e_perr, 0);
        check("a5_ferr", e_ferr, 0);
        idle_cycles(1);
        check("a5_dv_one_cycle", e_dv, 0);
        check("a5_pulse_count", e_pulses - p0, 1);
        idle_cycles(2);
        check("a5_hold_data", e_data, 8'hA5);

        // 0xA5 with flipped parity
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, lat);
        check("a5p_data", e_data, 8'hA5);
        check("a5p_perr", e_perr, 1);
        check("a5p_ferr", e_ferr, 0);
        idle_cycles(2);

        // 0x3C with bad stop bit, then clean 0x01
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, lat);
        check("3c_data", e_data, 8'h3C);
        check("3c_ferr", e_ferr, 1);
        check("3c_perr", e_perr, 0);
        idle_cycles(2);
        check("3c_idle_after_bad_stop", e_busy, 0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, lat);
        check("01_data", e_data, 8'h01);
        check("01_flags", {30'd0, e_perr, e_ferr}, 0);
        idle_cycles(2);

        // 0x5A with stalls: four extra cycles
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, lat);
        check("5a_latency", lat, 16);
        check("5a_dv", e_dv, 1);
        check("5a_data", e_data, 8'h5A);
        check("5a_flags", {30'd0, e_perr, e_ferr}, 0);
        idle_cycles(2);

        // Reset after data bit 4
        p0 = e_pulses;
        n = 0;
        drive_bit(1'b0, n);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, n);
        check("mid_busy", e_busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst_data_out", e_data, 0);
        check("rst_flags", {28'd0, e_dv, e_perr, e_ferr, e_busy}, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(12);
        check("rst_no_dv", e_pulses - p0, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, lat);
        check("ff_data", e_data, 8'hFF);
        check("ff_flags", {30'd0, e_perr, e_ferr}, 0);
        idle_cycles(2);

        // Odd parity: back-to-back 0x07 then 0x00
        p0 = o_pulses;
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, lat);
        check("odd07_dv", o_dv, 1);
        check("odd07_data", o_data, 8'h07);
        check("odd07_perr", o_perr, 0);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, lat);
        check("odd00_dv", o_dv, 1);
        check("odd00_data", o_data, 8'h00);
        check("odd00_perr", o_perr, 0);
        idle_cycles(1);
        check("odd_pulse_count", o_pulses - p0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
